// File: rtl/hamming_frame_sync_decoder_pkg.sv
// Shared constants and types for the serial Hamming(7,4) frame receiver.
package hamming_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'b0111_1110;
  localparam int         FRAME_BITS     = 64;
  localparam int         PAYLOAD_BITS   = 56;
  localparam int         CW_BITS        = 7;
  localparam int         DATA_BITS      = 4;
  localparam int         NUM_CW         = PAYLOAD_BITS / CW_BITS;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    HDR_CHK = 2'd2
  } rx_state_t;

endpackage

// File: rtl/hamming_frame_sync_decoder_decoder.sv
// Combinational Hamming(7,4) single-error-correcting decoder.
// cw[i] holds Hamming position i+1: p1 p2 d0 p4 d1 d2 d3.
module hamming_decoder_7_4
  import hamming_pkg::*;
(
  input  logic [CW_BITS-1:0]   cw,
  output logic [DATA_BITS-1:0] data,
  output logic                 corrected
);

  logic [2:0]         syn;
  logic [CW_BITS-1:0] fixed;

  always_comb begin
    syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    fixed  = cw;
    // A non-zero syndrome is the 1-based position of the flipped bit.
    if (syn != 3'd0) begin
      fixed[syn - 3'd1] = ~cw[syn - 3'd1];
    end
    corrected = (syn != 3'd0);
    data      = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end

endmodule

// File: rtl/hamming_frame_sync_decoder.sv
// Serial frame synchroniser: hunts for the header, flywheels on 64-bit frame
// timing and decodes the 8 Hamming(7,4) codewords of each payload.
module hamming_frame_sync_decoder
  import hamming_pkg::*;
#(
  parameter logic [7:0] HEADER     = HEADER_DEFAULT,
  parameter int         MISS_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        data_in,
  input  logic        data_valid,
  output logic [31:0] frame_data,
  output logic        frame_valid,
  output logic [3:0]  corr_count,
  output logic        header_miss,
  output logic        locked
);

  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  rx_state_t                 state_q, state_d;
  logic [7:0]                win_q, win_d, win_shift;
  logic [PAYLOAD_BITS-1:0]   pay_q, pay_d, pay_shift;
  logic [5:0]                bit_cnt_q, bit_cnt_d;
  logic [MISS_W-1:0]         miss_cnt_q, miss_cnt_d, miss_inc;
  logic                      pend_miss_q, pend_miss_d;
  logic [31:0]               frame_data_q, frame_data_d;
  logic                      frame_valid_q, frame_valid_d;
  logic [3:0]                corr_count_q, corr_count_d;
  logic                      header_miss_q, header_miss_d;
  logic                      locked_q, locked_d;

  logic [31:0]               dec_data;
  logic [NUM_CW-1:0]         corr_vec;
  logic [3:0]                corr_sum;

  assign win_shift = {win_q[6:0], data_in};
  assign pay_shift = {pay_q[PAYLOAD_BITS-2:0], data_in};
  assign miss_inc  = miss_cnt_q + MISS_W'(1);

  // Decode from the shifted value so the frame registers load on the 56th bit.
  generate
    for (genvar gi = 0; gi < NUM_CW; gi++) begin : g_dec
      hamming_decoder_7_4 u_dec (
        .cw        (pay_shift[CW_BITS*gi +: CW_BITS]),
        .data      (dec_data[DATA_BITS*gi +: DATA_BITS]),
        .corrected (corr_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    corr_sum = 4'd0;
    for (int i = 0; i < NUM_CW; i++) begin
      corr_sum = corr_sum + {3'd0, corr_vec[i]};
    end
  end

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    pay_d         = pay_q;
    bit_cnt_d     = bit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    pend_miss_d   = pend_miss_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    corr_count_d  = corr_count_q;
    header_miss_d = header_miss_q;
    locked_d      = locked_q;

    if (data_valid) begin
      case (state_q)
        HUNT: begin
          win_d = win_shift;
          if (win_shift == HEADER) begin
            state_d     = PAYLOAD;
            bit_cnt_d   = 6'd0;
            pend_miss_d = 1'b0;
          end
        end
        PAYLOAD: begin
          pay_d = pay_shift;
          if (bit_cnt_q == 6'(PAYLOAD_BITS - 1)) begin
            frame_valid_d = 1'b1;
            frame_data_d  = dec_data;
            corr_count_d  = corr_sum;
            header_miss_d = pend_miss_q;
            locked_d      = 1'b1;
            state_d       = HDR_CHK;
            bit_cnt_d     = 6'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
        HDR_CHK: begin
          win_d = win_shift;
          if (bit_cnt_q == 6'd7) begin
            bit_cnt_d = 6'd0;
            if (win_shift == HEADER) begin
              miss_cnt_d  = '0;
              pend_miss_d = 1'b0;
              state_d     = PAYLOAD;
            end else if (miss_inc == MISS_W'(MISS_LIMIT)) begin
              miss_cnt_d  = '0;
              pend_miss_d = 1'b0;
              locked_d    = 1'b0;
              state_d     = HUNT;
            end else begin
              // Flywheel: assume the header was corrupted and keep frame timing.
              miss_cnt_d  = miss_inc;
              pend_miss_d = 1'b1;
              state_d     = PAYLOAD;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      win_q         <= '0;
      pay_q         <= '0;
      bit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      pend_miss_q   <= 1'b0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      corr_count_q  <= '0;
      header_miss_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      pay_q         <= pay_d;
      bit_cnt_q     <= bit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      pend_miss_q   <= pend_miss_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      corr_count_q  <= corr_count_d;
      header_miss_q <= header_miss_d;
      locked_q      <= locked_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign corr_count  = corr_count_q;
  assign header_miss = header_miss_q;
  assign locked      = locked_q;

endmodule
